ipv4_src_arb: RTL and testbench
===============================

Name: ipv4_src_arb

Overview:
- Packet-level round-robin arbiter that shares one 512-bit IPv4 parser stage among NUM_SRC Avalon-ST sources.
- Grants one source for a whole SOP..EOP packet and forwards its beats through one registered stage.
- On the SOP beat, stamps the 4-bit source ID into internal-header bits [510:507], the field the downstream parser uses to pick its NoC destination.
- Enforces a per-packet beat limit and flushes protocol-violating beats.

Parameters:
- NUM_SRC, 4, number of requesting sources (1..16)
- MAX_BEATS, 32, maximum beats per packet before forced termination (2..255)
- W, 512, data width in bits; empty field is $clog2(W/8) bits

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  NUM_SRC  per-source beat valid
- in_sop  in  NUM_SRC  per-source start of packet
- in_eop  in  NUM_SRC  per-source end of packet
- in_error  in  NUM_SRC  per-source error flag
- in_empty  in  NUM_SRC x 6  per-source empty bytes
- in_data  in  NUM_SRC x W  per-source data
- in_ready  out  NUM_SRC  per-source ready
- out_valid/out_sop/out_eop/out_error  out  1 each  to parser
- out_empty  out  6  to parser
- out_data  out  W  to parser
- out_ready  in  1  parser backpressure
- o_src_id  out  4  source currently granted
- o_busy  out  1  a packet is in flight
- o_trunc_cnt  out  16  saturating count of truncated packets
- o_flush_cnt  out  16  saturating count of flushed orphan beats

Behaviour:
- Reset (async assert, sync release): all out_* = 0, o_src_id = 0, o_busy = 0, counters = 0, rr pointer = 0, state IDLE.
- FSM states:
  - IDLE → PKT: when out_ready and any in_valid[i] & in_sop[i]. Winner is the first such i searching from rr_ptr upward, modulo NUM_SRC. Latch grant = i; rr_ptr <= i+1 (wraps to 0).
  - PKT → IDLE: when the granted source's accepted beat has eop=1, or the beat counter reaches MAX_BEATS.
- Single-beat packet (sop & eop): accepted in the granting cycle; FSM stays IDLE and rr_ptr still advances.
- in_ready[i]:
  - IDLE: 1 for the winner when out_ready.
  - PKT: in_ready[grant] = out_ready; all others 0.
  - Orphan flush: in IDLE, a source with valid & !sop gets in_ready = 1, its beat is discarded and o_flush_cnt increments (one per source per cycle, summed). A source that also wins arbitration is never flushed.
- Beat acceptance = in_valid[i] & in_ready[i]. The output register loads only when out_ready=1; otherwise it holds. Latency: accepted beat appears on out_* the next cycle.
- When out_ready=1 and no beat is accepted, out_valid <= 0.
- SOP stamping: out_data[510:507] <= grant index; all other bits pass unchanged. o_src_id follows the grant.
- Beat counter: 8 bits, cleared to 1 on the SOP accept, +1 per accepted beat.
- Truncation: if an accepted beat brings the counter to MAX_BEATS without eop, that beat is emitted with eop=1 and error=1. o_trunc_cnt increments and FSM returns to IDLE. Remaining source beats are later flushed as orphans.
- A granted-source beat with sop=1 while in PKT is forwarded with error=1. The packet continues and is not restarted.
- Counters saturate at 16'hFFFF.
- o_busy = (state == PKT).
- Reset mid-packet: output register and FSM clear immediately. Any partial packet is lost; the next packet starts fresh at rr_ptr = 0.

Test Plan:
- Reset, then src2 sends a 3-beat packet with out_ready=1 → out beats appear 1 cycle later; beat 1 has out_data[510:507]=4'd2, out_sop=1; beat 3 has out_eop=1; o_busy high for 2 cycles.
- All 4 sources hold 2-beat packets → grant order 0,1,2,3,0 with no interleaving; each SOP stamped 0,1,2,3 respectively.
- out_ready toggles 1,0,1,0 mid-packet from src1 → all in_ready=0 and out_* frozen while low; no beat lost or duplicated; stamped ID stays 4'd1.
- MAX_BEATS=4, src0 sends 6 beats without eop until beat 6 → out beat 4 has eop=1, error=1; o_trunc_cnt=1; beats 5–6 flushed, o_flush_cnt=2.
- In IDLE, src3 presents valid & !sop for 3 cycles while src1 offers sop → src1 granted first cycle; src3 flushed on all 3 IDLE cycles it is not blocked; o_flush_cnt=3, src3 beats never reach out_*.
- Assert reset_n=0 asynchronously mid-packet (beat 2 of 4) → out_valid=0 and o_busy=0 immediately, no clock edge needed; after release, the next src0 SOP is granted first.

Source files
------------

// File: rtl/ipv4_src_arb.sv
// Packet-level round-robin arbiter sharing one parser stage; stamps source ID into data[W-2 -: 4] on SOP.
// Latency 1 (registered stage); out_ready=0 freezes the stage and holds every in_ready low except IDLE orphan flushes.
module ipv4_src_arb #(
  parameter int NUM_SRC   = 4,
  parameter int MAX_BEATS = 32,
  parameter int W         = 512,
  localparam int EW       = $clog2(W/8)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_SRC-1:0]    in_valid,
  input  logic [NUM_SRC-1:0]    in_sop,
  input  logic [NUM_SRC-1:0]    in_eop,
  input  logic [NUM_SRC-1:0]    in_error,
  input  logic [NUM_SRC*EW-1:0] in_empty,
  input  logic [NUM_SRC*W-1:0]  in_data,
  output logic [NUM_SRC-1:0]    in_ready,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_error,
  output logic [EW-1:0]         out_empty,
  output logic [W-1:0]          out_data,
  input  logic                  out_ready,
  output logic [3:0]            o_src_id,
  output logic                  o_busy,
  output logic [15:0]           o_trunc_cnt,
  output logic [15:0]           o_flush_cnt
);

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic          err;
    logic [EW-1:0] empty;
    logic [W-1:0]  data;
  } beat_t;

  typedef enum logic {IDLE, PKT} state_t;

  state_t        state_q;
  logic [3:0]    grant_q, rr_ptr_q;
  logic [7:0]    cnt_q, cnt_d;
  beat_t         out_q, out_d;
  logic          out_vld_q;
  logic [15:0]   trunc_cnt_q, trunc_cnt_d;
  logic [15:0]   flush_cnt_q, flush_cnt_d;

  // Sources padded to 16 so a 4-bit index always selects a legal element.
  beat_t         src_beat [16];
  logic [15:0]   vld16, sop_req;

  for (genvar i = 0; i < 16; i++) begin : g_src
    if (i < NUM_SRC) begin : g_used
      assign src_beat[i] = {in_sop[i], in_eop[i], in_error[i], in_empty[i*EW +: EW], in_data[i*W +: W]};
      assign vld16[i]    = in_valid[i];
      assign sop_req[i]  = in_valid[i] & in_sop[i];
    end else begin : g_pad
      assign src_beat[i] = '0;
      assign vld16[i]    = 1'b0;
      assign sop_req[i]  = 1'b0;
    end
  end

  logic          in_idle, win_vld, acc, trunc, last;
  logic [3:0]    win_idx, sel, rr_nxt;
  logic [4:0]    cand;
  beat_t         sel_beat;
  logic [NUM_SRC-1:0] ready, flush;
  logic [4:0]    flush_sum;
  logic [16:0]   flush_add;

  assign in_idle = (state_q == IDLE);

  // First SOP requester at or above rr_ptr_q, wrapping modulo NUM_SRC.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = 5'(rr_ptr_q) + 5'(k);
      if (cand >= 5'(NUM_SRC)) cand = cand - 5'(NUM_SRC);
      if (!win_vld && sop_req[cand[3:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[3:0];
      end
    end
  end

  assign rr_nxt   = (win_idx == 4'(NUM_SRC - 1)) ? 4'd0 : win_idx + 4'd1;
  assign sel      = in_idle ? win_idx : grant_q;
  assign sel_beat = src_beat[sel];
  assign acc      = out_ready & (in_idle ? win_vld : vld16[grant_q]);
  assign cnt_d    = in_idle ? 8'd1 : cnt_q + 8'd1;
  assign trunc    = acc & ~sel_beat.eop & (cnt_d == 8'(MAX_BEATS));
  assign last     = acc & (sel_beat.eop | (cnt_d == 8'(MAX_BEATS)));

  always_comb begin
    out_d      = sel_beat;
    out_d.eop  = sel_beat.eop | trunc;
    out_d.err  = sel_beat.err | trunc | (~in_idle & sel_beat.sop);
    if (in_idle) out_d.data[W-2 -: 4] = win_idx;
  end

  // Orphan (valid without SOP) beats are drained only while no packet is in flight.
  always_comb begin
    ready     = '0;
    flush     = '0;
    flush_sum = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      flush[i] = in_idle & in_valid[i] & ~in_sop[i];
      if (in_idle) ready[i] = flush[i] | (out_ready & win_vld & (win_idx == 4'(i)));
      else         ready[i] = out_ready & (grant_q == 4'(i));
      flush_sum = flush_sum + 5'(flush[i]);
    end
  end

  assign flush_add   = {1'b0, flush_cnt_q} + 17'(flush_sum);
  assign flush_cnt_d = flush_add[16] ? 16'hFFFF : flush_add[15:0];
  assign trunc_cnt_d = (trunc && trunc_cnt_q != 16'hFFFF) ? trunc_cnt_q + 16'd1 : trunc_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      trunc_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_ready) begin
        out_vld_q <= acc;
        if (acc) out_q <= out_d;
      end
      trunc_cnt_q <= trunc_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      case (state_q)
        IDLE: begin
          if (acc) begin
            grant_q  <= win_idx;
            rr_ptr_q <= rr_nxt;
            cnt_q    <= cnt_d;
            if (!sel_beat.eop) state_q <= PKT;
          end
        end
        PKT: begin
          if (acc) begin
            cnt_q <= cnt_d;
            if (last) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = ready;
  assign out_valid   = out_vld_q;
  assign out_sop     = out_q.sop;
  assign out_eop     = out_q.eop;
  assign out_error   = out_q.err;
  assign out_empty   = out_q.empty;
  assign out_data    = out_q.data;
  assign o_src_id    = grant_q;
  assign o_busy      = (state_q == PKT);
  assign o_trunc_cnt = trunc_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ipv4_src_arb.sv
// Bench for ipv4_src_arb: directed scenarios plus randomized packets against a per-source packet-level model.
module tb_ipv4_src_arb;
  localparam int NS = 4;
  localparam int MB = 4;
  localparam int W  = 512;
  localparam int EW = 6;

  logic clk = 1'b0;
  logic reset_n;
  logic [NS-1:0] in_valid, in_sop, in_eop, in_error, in_ready;
  logic [NS*EW-1:0] in_empty;
  logic [NS*W-1:0] in_data;
  logic out_valid, out_sop, out_eop, out_error, out_ready;
  logic [EW-1:0] out_empty;
  logic [W-1:0] out_data;
  logic [3:0] o_src_id;
  logic o_busy;
  logic [15:0] o_trunc_cnt, o_flush_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic sop;
    logic eop;
    logic err;
    logic [EW-1:0] empty;
    logic [W-1:0] data;
  } beat_t;

  beat_t src_q [NS][$];
  beat_t exp_q [NS][$];
  int exp_trunc, exp_flush;
  int order_q [$];
  bit in_pkt;
  int cur;

  ipv4_src_arb #(.NUM_SRC(NS), .MAX_BEATS(MB), .W(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_error(in_error),
    .in_empty(in_empty), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_error(out_error),
    .out_empty(out_empty), .out_data(out_data), .out_ready(out_ready),
    .o_src_id(o_src_id), .o_busy(o_busy), .o_trunc_cnt(o_trunc_cnt), .o_flush_cnt(o_flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] r;
    for (int k = 0; k < W/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] stamp(input logic [W-1:0] d, input int id);
    logic [W-1:0] r;
    r = d;
    r[W-2 -: 4] = 4'(id);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_sop = '0; in_eop = '0; in_error = '0; in_empty = '0; in_data = '0;
  endtask

  task automatic set_src(input int s, input bit v, input bit sop, input bit eop, input logic [W-1:0] d);
    in_valid[s] = v; in_sop[s] = sop; in_eop[s] = eop; in_error[s] = 1'b0;
    in_empty[s*EW +: EW] = '0;
    in_data[s*W +: W] = d;
  endtask

  task automatic do_reset();
    idle_inputs();
    out_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_trunc = 0;
    exp_flush = 0;
    in_pkt = 1'b0;
    order_q.delete();
  endtask

  // Expected stream per source follows the packet rules directly: stamp first beat,
  // force eop/error on the MB-th beat without eop, and count later beats as flushed.
  task automatic push_pkt(input int s, input int len, input bit eop_end);
    beat_t b, e;
    for (int k = 1; k <= len; k++) begin
      b.sop = (k == 1);
      b.eop = (k == len) && eop_end;
      b.err = ($urandom_range(0, 7) == 0);
      b.empty = EW'($urandom);
      b.data = rnd_data();
      src_q[s].push_back(b);
      e = b;
      if (k == 1) e.data = stamp(b.data, s);
      if (k < MB || (k == MB && b.eop)) exp_q[s].push_back(e);
      else if (k == MB) begin
        e.eop = 1'b1; e.err = 1'b1;
        exp_q[s].push_back(e);
        exp_trunc++;
      end else exp_flush++;
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NS; i++) n += src_q[i].size() + exp_q[i].size();
    return n;
  endfunction

  task automatic check_out();
    beat_t e;
    bit avail;
    if (out_sop) begin
      chk("interleave", in_pkt, 1'b0);
      cur = int'(out_data[W-2 -: 4]);
      order_q.push_back(cur);
    end else chk("mid_pkt_beat", in_pkt, 1'b1);
    chk("src_id", o_src_id, cur);
    avail = (cur < NS) && (exp_q[cur % NS].size() > 0);
    chk("beat_expected", avail, 1'b1);
    if (avail) begin
      e = exp_q[cur].pop_front();
      chk("beat_sop", out_sop, e.sop);
      chk("beat_eop", out_eop, e.eop);
      chk("beat_err", out_error, e.err);
      chk("beat_empty", out_empty, e.empty);
      chk("beat_data", out_data, e.data);
    end
    in_pkt = !out_eop;
  endtask

  task automatic drain(input int vprob, input int rprob, input int maxcyc);
    beat_t b;
    logic [NS-1:0] acc;
    int cyc = 0;
    while (cyc < maxcyc && pending() > 0) begin
      for (int i = 0; i < NS; i++) begin
        if (src_q[i].size() > 0 && $urandom_range(1, 100) <= vprob) begin
          b = src_q[i][0];
          in_valid[i] = 1'b1; in_sop[i] = b.sop; in_eop[i] = b.eop; in_error[i] = b.err;
          in_empty[i*EW +: EW] = b.empty;
          in_data[i*W +: W] = b.data;
        end else begin
          in_valid[i] = 1'b0; in_sop[i] = 1'b0; in_eop[i] = 1'b0; in_error[i] = 1'b0;
        end
      end
      out_ready = ($urandom_range(1, 100) <= rprob);
      @(negedge clk);
      acc = in_valid & in_ready;
      if (out_valid && out_ready) check_out();
      tick();
      for (int i = 0; i < NS; i++) if (acc[i]) void'(src_q[i].pop_front());
      cyc++;
    end
    chk("drain_left", pending(), 0);
    idle_inputs();
  endtask

  initial begin
    logic [W-1:0] d1, d2, d3, da;
    logic [W-1:0] dt [6];
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    reset_n = 1'b0;
    idle_inputs();
    out_ready = 1'b0;
    do_reset();

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_flags", {out_sop, out_eop, out_error}, 0);
    chk("rst_out_empty", out_empty, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_src_id", o_src_id, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_trunc", o_trunc_cnt, 0);
    chk("rst_flush", o_flush_cnt, 0);
    chk("rst_in_ready", in_ready, 0);

    // src2 3-beat packet
    out_ready = 1'b1;
    d1 = rnd_data(); d2 = rnd_data(); d3 = rnd_data();
    set_src(2, 1, 1, 0, d1); #1;
    chk("t1_rdy1", in_ready, 4'b0100);
    tick();
    chk("t1_v1", out_valid, 1);
    chk("t1_sop1", out_sop, 1);
    chk("t1_stamp", out_data[W-2 -: 4], 4'd2);
    chk("t1_d1", out_data, stamp(d1, 2));
    chk("t1_busy1", o_busy, 1);
    chk("t1_id", o_src_id, 2);
    set_src(2, 1, 0, 0, d2); #1;
    chk("t1_rdy2", in_ready, 4'b0100);
    tick();
    chk("t1_sop2", out_sop, 0);
    chk("t1_d2", out_data, d2);
    chk("t1_busy2", o_busy, 1);
    set_src(2, 1, 0, 1, d3);
    tick();
    chk("t1_eop3", out_eop, 1);
    chk("t1_d3", out_data, d3);
    chk("t1_busy3", o_busy, 0);
    set_src(2, 0, 0, 0, '0);
    tick();
    chk("t1_v_end", out_valid, 0);

    // Round-robin across four sources, src0 with two packets
    do_reset();
    push_pkt(0, 2, 1); push_pkt(0, 2, 1);
    for (int s = 1; s < NS; s++) push_pkt(s, 2, 1);
    drain(100, 100, 200);
    chk("rr_count", order_q.size(), 5);
    for (int k = 0; k < 5; k++) chk("rr_order", (k < order_q.size()) ? order_q[k] : -1, exp_order[k]);

    // Backpressure mid-packet from src1
    d1 = rnd_data(); d2 = rnd_data(); d3 = rnd_data();
    out_ready = 1'b1;
    set_src(1, 1, 1, 0, d1); #1;
    chk("bp_rdy1", in_ready, 4'b0010);
    tick();
    chk("bp_d1", out_data, stamp(d1, 1));
    out_ready = 1'b0;
    set_src(1, 1, 0, 0, d2); set_src(0, 1, 1, 1, rnd_data()); #1;
    chk("bp_rdy_lo1", in_ready, 4'b0000);
    tick();
    chk("bp_hold_v", out_valid, 1);
    chk("bp_hold_sop", out_sop, 1);
    chk("bp_hold_d1", out_data, stamp(d1, 1));
    out_ready = 1'b1;
    set_src(0, 0, 0, 0, '0); #1;
    chk("bp_rdy2", in_ready, 4'b0010);
    tick();
    chk("bp_d2", out_data, d2);
    chk("bp_sop2", out_sop, 0);
    out_ready = 1'b0;
    set_src(1, 1, 0, 1, d3); #1;
    chk("bp_rdy_lo2", in_ready, 4'b0000);
    tick();
    chk("bp_hold_d2", out_data, d2);
    chk("bp_hold_eop", out_eop, 0);
    out_ready = 1'b1; #1;
    chk("bp_rdy3", in_ready, 4'b0010);
    tick();
    chk("bp_d3", out_data, d3);
    chk("bp_eop3", out_eop, 1);
    chk("bp_id", o_src_id, 1);
    set_src(1, 0, 0, 0, '0);
    tick();
    chk("bp_v_end", out_valid, 0);

    // Truncation at MB beats, remaining beats flushed
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) dt[k] = rnd_data();
    for (int k = 1; k <= 6; k++) begin
      set_src(0, 1, k == 1, k == 6, dt[k-1]); #1;
      chk("tr_rdy", in_ready[0], 1);
      tick();
      if (k == 3) chk("tr_eop3", out_eop, 0);
      if (k == 4) begin
        chk("tr_v4", out_valid, 1);
        chk("tr_eop4", out_eop, 1);
        chk("tr_err4", out_error, 1);
        chk("tr_d4", out_data, dt[3]);
        chk("tr_busy4", o_busy, 0);
      end
      if (k >= 5) chk("tr_flushed_v", out_valid, 0);
    end
    idle_inputs();
    chk("tr_trunc_cnt", o_trunc_cnt, 1);
    chk("tr_flush_cnt", o_flush_cnt, 2);

    // Orphan flush alongside a single-beat grant
    do_reset();
    out_ready = 1'b1;
    da = rnd_data();
    set_src(1, 1, 1, 1, da); set_src(3, 1, 0, 0, rnd_data()); #1;
    chk("of_rdy1", in_ready, 4'b1010);
    tick();
    chk("of_v1", out_valid, 1);
    chk("of_d1", out_data, stamp(da, 1));
    chk("of_eop1", out_eop, 1);
    chk("of_busy", o_busy, 0);
    set_src(1, 0, 0, 0, '0);
    for (int k = 0; k < 2; k++) begin
      set_src(3, 1, 0, k == 1, rnd_data()); #1;
      chk("of_rdy", in_ready, 4'b1000);
      tick();
      chk("of_no_out", out_valid, 0);
    end
    idle_inputs();
    chk("of_flush_cnt", o_flush_cnt, 3);

    // Asynchronous reset mid-packet
    do_reset();
    out_ready = 1'b1;
    set_src(0, 1, 1, 0, rnd_data());
    tick();
    set_src(0, 1, 0, 0, rnd_data());
    tick();
    chk("ar_pre_busy", o_busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_busy", o_busy, 0);
    idle_inputs();
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    da = rnd_data();
    set_src(0, 1, 1, 1, da); set_src(1, 1, 1, 1, rnd_data()); #1;
    chk("ar_rdy", in_ready, 4'b0001);
    tick();
    chk("ar_d", out_data, stamp(da, 0));
    chk("ar_id", o_src_id, 0);
    idle_inputs();
    tick();

    // Randomized packets with gaps and random backpressure
    do_reset();
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 7);
      push_pkt($urandom_range(0, NS - 1), len, (len > MB) ? bit'($urandom_range(0, 1)) : 1'b1);
    end
    drain(70, 60, 5000);
    chk("rnd_trunc_cnt", o_trunc_cnt, exp_trunc);
    chk("rnd_flush_cnt", o_flush_cnt, exp_flush);
    chk("rnd_busy_end", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
